// File: rtl/replay_cmd_fifo_pkg.sv
// Shared command-path types: the command packet layout and FIFO sizing defaults.
package cmd_pkg;

  // Command packet as produced by the decoder and consumed by the PE-array scheduler.
  typedef struct packed {
    logic [7:0]  opcode;
    logic [7:0]  pe_id;
    logic [15:0] addr;
    logic [31:0] operand;
  } com_packet;

  localparam int unsigned com_fifo_size = 16;
  localparam int unsigned DATA_W        = $bits(com_packet);

endpackage

// File: rtl/replay_cmd_fifo_ram.sv
// Simple dual-port storage for replay_cmd_fifo: one write port, one registered read port.
//   clk, reset      : clock, async active-high reset (clears the read register only)
//   we/waddr/wdata  : write port
//   re/raddr        : read enable and address
//   rdata           : registered read data, 0 in the cycle after re was low
module replay_cmd_fifo_ram #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage array, no reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register returns zero whenever no read was issued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
    else         rdata <= '0;
  end

endmodule

// File: rtl/replay_cmd_fifo.sv
// Command FIFO with iteration replay: read entries are retained until committed,
// and replay rewinds the read side to the last committed point.
//   clk, reset            : clock, async active-high reset
//   flush                 : synchronous clear of all pointers and read outputs
//   winc/wdata            : write request and packet
//   wfull/walmost_full    : retained space full / at or above AFULL_TH
//   wr_drop               : one-cycle pulse after a write attempted while full
//   rinc                  : read request
//   rdata/rvalid          : read data valid one cycle after an accepted read
//   rempty                : nothing pending to read
//   replay                : rewind read pointer to base
//   commit                : release consumed entries (base <= read pointer)
//   pending_cnt           : wr_ptr - rd_ptr
//   retained_cnt          : wr_ptr - base_ptr
module replay_cmd_fifo #(
  parameter int unsigned DATA_W   = cmd_pkg::DATA_W,
  parameter int unsigned DEPTH    = cmd_pkg::com_fifo_size,
  parameter int unsigned AFULL_TH = DEPTH - 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          winc,
  input  logic [DATA_W-1:0]             wdata,
  output logic                          wfull,
  output logic                          walmost_full,
  output logic                          wr_drop,
  input  logic                          rinc,
  output logic [DATA_W-1:0]             rdata,
  output logic                          rvalid,
  output logic                          rempty,
  input  logic                          replay,
  input  logic                          commit,
  output logic [$clog2(DEPTH):0]        pending_cnt,
  output logic [$clog2(DEPTH):0]        retained_cnt
);

  import cmd_pkg::*;

  localparam int unsigned PW = $clog2(DEPTH) + 1;
  localparam int unsigned AW = PW - 1;

  logic [PW-1:0] wr_ptr, rd_ptr, base_ptr;
  logic          wr_en, rd_en;

  // Occupancy and flags decode straight from the registered pointers; the
  // extra wrap bit makes modulo subtraction distinguish full from empty.
  assign pending_cnt  = wr_ptr - rd_ptr;
  assign retained_cnt = wr_ptr - base_ptr;
  assign wfull        = (retained_cnt == PW'(DEPTH));
  assign walmost_full = (retained_cnt >= PW'(AFULL_TH));
  assign rempty       = (pending_cnt == '0);

  assign wr_en = winc && !wfull && !flush;
  assign rd_en = rinc && !rempty && !replay && !flush;

  // Pointer update: flush > replay > commit; commit captures rd_ptr before this cycle's read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      base_ptr <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      base_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (replay) begin
        rd_ptr <= base_ptr;
      end else begin
        if (commit) base_ptr <= rd_ptr;
        if (rd_en)  rd_ptr   <= rd_ptr + PW'(1);
      end
    end
  end

  // Read-valid and drop pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid  <= 1'b0;
      wr_drop <= 1'b0;
    end else begin
      rvalid  <= rd_en;
      wr_drop <= winc && wfull && !flush;
    end
  end

  replay_cmd_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (wr_en),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wdata),
    .re    (rd_en),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_replay_cmd_fifo.sv
// Self-checking bench for replay_cmd_fifo (DEPTH=8): directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_replay_cmd_fifo;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned DW    = 64;

  logic          clk = 1'b0;
  logic          reset, flush, winc, rinc, replay, commit;
  logic [DW-1:0] wdata;
  logic          wfull, walmost_full, wr_drop, rvalid, rempty;
  logic [DW-1:0] rdata;
  logic [3:0]    pending_cnt, retained_cnt;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  // Reference: queue of retained packets (oldest = iteration base) and the
  // number of those already consumed in the current iteration.
  logic [DW-1:0] mq[$];
  int            rd_off = 0;
  logic [DW-1:0] e_rdata = '0;
  logic          e_rvalid = 1'b0;
  logic          e_drop = 1'b0;

  replay_cmd_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .AFULL_TH(DEPTH-2)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .winc         (winc),
    .wdata        (wdata),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wr_drop      (wr_drop),
    .rinc         (rinc),
    .rdata        (rdata),
    .rvalid       (rvalid),
    .rempty       (rempty),
    .replay       (replay),
    .commit       (commit),
    .pending_cnt  (pending_cnt),
    .retained_cnt (retained_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    rd_off   = 0;
    e_rdata  = '0;
    e_rvalid = 1'b0;
    e_drop   = 1'b0;
  endtask

  // One clock of the FIFO rules, evaluated on the pre-edge state.
  task automatic model_step();
    int size  = mq.size();
    bit full  = (size == DEPTH);
    bit empty = ((size - rd_off) == 0);
    bit rd;
    int n;
    e_drop = winc && full && !flush;
    if (flush) begin
      mq.delete();
      rd_off   = 0;
      e_rdata  = '0;
      e_rvalid = 1'b0;
    end else begin
      rd       = rinc && !empty && !replay;
      e_rvalid = rd;
      e_rdata  = rd ? mq[rd_off] : '0;
      if (replay) begin
        rd_off = 0;
      end else if (commit) begin
        n = rd_off;
        for (int i = 0; i < n; i++) void'(mq.pop_front());
        rd_off = rd ? 1 : 0;
      end else if (rd) begin
        rd_off++;
      end
      if (winc && !full) mq.push_back(wdata);
    end
  endtask

  // Apply one cycle of inputs; returns at the following falling edge.
  task automatic cyc(bit w, logic [DW-1:0] d, bit r, bit rp, bit cm, bit fl);
    #1;
    winc = w; wdata = d; rinc = r; replay = rp; commit = cm; flush = fl;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_on && !reset) begin
      chk("rdata",        rdata,        e_rdata);
      chk("rvalid",       64'(rvalid),  64'(e_rvalid));
      chk("wr_drop",      64'(wr_drop), 64'(e_drop));
      chk("pending_cnt",  64'(pending_cnt),  64'(mq.size() - rd_off));
      chk("retained_cnt", 64'(retained_cnt), 64'(mq.size()));
      chk("rempty",       64'(rempty),  64'((mq.size() - rd_off) == 0));
      chk("wfull",        64'(wfull),   64'(mq.size() == DEPTH));
      chk("walmost_full", 64'(walmost_full), 64'(mq.size() >= DEPTH - 2));
    end
  end

  initial begin
    reset = 1'b1; flush = 1'b0; winc = 1'b0; rinc = 1'b0;
    replay = 1'b0; commit = 1'b0; wdata = '0;
    repeat (2) @(negedge clk);
    chk("reset_rempty", 64'(rempty), 64'd1);
    chk("reset_wfull",  64'(wfull),  64'd0);
    chk("reset_retained", 64'(retained_cnt), 64'd0);
    chk("reset_rvalid", 64'(rvalid), 64'd0);
    #1 reset = 1'b0;
    model_reset();
    chk_on = 1'b1;

    // Fill, overflow, drain.
    for (int i = 1; i <= 8; i++) cyc(1'b1, 64'(8'hA0 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    chk("fill8_wfull", 64'(wfull), 64'd1);
    chk("fill8_retained", 64'(retained_cnt), 64'd8);
    cyc(1'b1, 64'hA9, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("overflow_drop", 64'(wr_drop), 64'd1);
    idle();
    chk("drop_pulse_end", 64'(wr_drop), 64'd0);
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("drain_rdata", rdata, 64'(8'hA0 + i));
    end
    idle();
    chk("drained_rempty", 64'(rempty), 64'd1);
    chk("drained_retained", 64'(retained_cnt), 64'd8);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("empty_read_rvalid", 64'(rvalid), 64'd0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("commit_all_retained", 64'(retained_cnt), 64'd0);

    // Replay of a 3-packet iteration.
    for (int i = 1; i <= 3; i++) cyc(1'b1, 64'(8'hB0 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rp_pending3", 64'(pending_cnt), 64'd3);
    repeat (3) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rp_pending0", 64'(pending_cnt), 64'd0);
    cyc(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("rp_rewound", 64'(pending_cnt), 64'd3);
    chk("rp_read_ignored", 64'(rvalid), 64'd0);
    for (int i = 1; i <= 3; i++) begin
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("rp_rdata", rdata, 64'(8'hB0 + i));
    end
    chk("rp_pending_end", 64'(pending_cnt), 64'd0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Commit frees space only after it lands.
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 8; i++) cyc(1'b1, 64'(8'hC0 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (4) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("commit_retained4", 64'(retained_cnt), 64'd4);
    chk("commit_wfull0", 64'(wfull), 64'd0);
    for (int i = 9; i <= 12; i++) cyc(1'b1, 64'(8'hC0 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    chk("refill_wfull", 64'(wfull), 64'd1);
    cyc(1'b1, 64'hCD, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("refill_drop", 64'(wr_drop), 64'd1);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("refill_first", rdata, 64'hC5);

    // Replay + commit together: replay wins.
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 4; i++) cyc(1'b1, 64'(8'hD0 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("rpcm_retained", 64'(retained_cnt), 64'd4);
    chk("rpcm_pending", 64'(pending_cnt), 64'd4);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rpcm_reread", rdata, 64'hD1);

    // Pointer wrap.
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 64'(16'hE000 + i), 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 64'(16'hE800 + i), 1'b1, 1'b0, 1'b0, 1'b0);
      chk("wrap_rdata", rdata, 64'(16'hE000 + i));
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("wrap_rdata2", rdata, 64'(16'hE800 + i));
    end

    // Async reset kills an accepted read.
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 5; i++) cyc(1'b1, 64'(8'hF0 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    #1 winc = 1'b0; rinc = 1'b1;
    @(posedge clk);
    model_step();
    #2 reset = 1'b1; rinc = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_pending", 64'(pending_cnt), 64'd0);
    chk("rst_retained", 64'(retained_cnt), 64'd0);
    chk("rst_rempty", 64'(rempty), 64'd1);
    #1 reset = 1'b0;
    cyc(1'b1, 64'h77, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("post_rst_rdata", rdata, 64'h77);

    // Flush with a read request in the same cycle.
    for (int i = 1; i <= 5; i++) cyc(1'b1, 64'(8'h90 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("fl_rvalid", 64'(rvalid), 64'd0);
    chk("fl_retained", 64'(retained_cnt), 64'd0);
    chk("fl_rempty", 64'(rempty), 64'd1);
    cyc(1'b1, 64'h88, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("post_fl_rdata", rdata, 64'h88);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom % 10) < 6, {$urandom, $urandom}, ($urandom % 2) == 0,
          ($urandom % 16) == 0, ($urandom % 6) == 0, ($urandom % 97) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/replay_cmd_fifo.md
Name: replay_cmd_fifo

Overview:
Parametrised next-generation command FIFO sitting between the command decoder and the PE-array scheduler. It buffers command packets and supports iteration replay: consumed entries stay retained until committed. A replay request rewinds the read side to the start of the current iteration without rewriting. It adds flush, occupancy counts, almost-full, a registered read-valid and a write-drop indication.

Parameters:
DATA_W, 64, command packet width in bits (a com_packet-sized vector).
DEPTH, 16, entries; power of two, at least 4.
AFULL_TH, DEPTH-2, `walmost_full` asserts when retained_cnt >= AFULL_TH.
PW, $clog2(DEPTH)+1, pointer/count width (derived, not overridable).

Ports:
clk  in  1  single clock, all logic on rising edge
reset  in  1  asynchronous, active-high; clears all state
flush  in  1  synchronous clear of all pointers
winc  in  1  write request
wdata  in  DATA_W  packet to write
wfull  out  1  retained_cnt == DEPTH
walmost_full  out  1  retained_cnt >= AFULL_TH
wr_drop  out  1  one-cycle pulse: winc while full, write discarded
rinc  in  1  read request
rdata  out  DATA_W  registered read data; 0 when rvalid=0
rvalid  out  1  rdata holds the packet accepted the previous cycle
rempty  out  1  pending_cnt == 0
replay  in  1  rewind read pointer to iteration base
commit  in  1  release consumed entries (base <= read pointer)
pending_cnt  out  PW  wr_ptr - rd_ptr
retained_cnt  out  PW  wr_ptr - base_ptr

Behaviour:
- State: wr_ptr, rd_ptr and base_ptr, each PW bits with a wrap bit. RAM address is the low PW-1 bits. Subtraction is modulo 2^PW.
- Invariant: base_ptr <= rd_ptr <= wr_ptr in ring order.
- Reset (async) and flush (sync): all pointers = 0, rdata = 0, rvalid = 0, wr_drop = 0. Outputs: rempty = 1, wfull = 0, walmost_full = 0, counts = 0.
- A reset or flush asserted mid-read kills the pending rvalid.
- Write is accepted when winc && !wfull && !flush. The RAM is written at wr_ptr and wr_ptr increments.
- winc && wfull: no state change; wr_drop = 1 the next cycle.
- Full is measured against base_ptr, not rd_ptr. Consumed but uncommitted entries still occupy space.
- Read is accepted when rinc && !rempty && !replay && !flush. The RAM is read at rd_ptr and rd_ptr increments. rdata and rvalid are valid exactly 1 cycle later.
- rinc when empty: ignored; rvalid = 0 next cycle.
- replay: rd_ptr <= base_ptr. Any rinc in the same cycle is ignored. The first replayed packet can be read the following cycle.
- commit: base_ptr <= rd_ptr. The rd_ptr used is the value before any same-cycle read increment; a same-cycle read is not committed.
- Priority: flush > replay > commit.
- replay and commit in the same cycle: replay wins and commit is ignored, so retained entries are preserved.
- A write may proceed in the same cycle as replay or commit. wfull is evaluated on pre-update pointers, so commit frees space the next cycle, not the same cycle.
- Simultaneous write and read when pending_cnt = 0: the read is not accepted (rempty), and the write lands.
- Wrap-around: pointers roll over from 2^PW-1 to 0. Counts stay correct across the wrap (tested at DEPTH boundary).
- No combinational path from any input to any output. All outputs are registered or decoded from registered pointers.

Decomposition:
- Shared package (cmd_pkg): com_packet typedef, com_fifo_size default (16), and a DATA_W constant derived from $bits(com_packet).
- One sub-module, replay_cmd_fifo_ram: a simple dual-port RAM with one write port and one registered read port. Its read output returns 0 when the read enable is low.
- Pointer, count and flag logic stays in the top module.

Test Plan:
- Reset with DEPTH=8: write 0xA1..0xA8 -> wfull=1 after the 8th write, and the 9th write gives wr_drop=1 for one cycle. Read 8 times -> rdata 0xA1..0xA8, each 1 cycle after rinc; rempty=1 and retained_cnt=8.
- Write 3 packets, read 3, assert replay, read 3 -> the same 3 packets are returned in order; pending_cnt goes 3 -> 0 -> 3 -> 0.
- Fill 8, read 4, commit -> retained_cnt=4 and wfull=0 next cycle; 4 further writes are accepted and the 5th is dropped.
- replay and commit in the same cycle after 2 reads -> base_ptr unchanged and rd_ptr=base, so retained_cnt and pending_cnt both equal the write count.
- Wrap: run 20 write/read/commit cycles at DEPTH=8 -> data order is preserved across pointer rollover and counts never exceed 8.
- Assert reset, and separately flush, while rinc is accepted with 5 entries held -> rvalid=0 next cycle, all counts 0, rempty=1; the next write/read returns the new data.
